// File: rtl/alu_seq.sv
// Registered ALU: single-cycle logic/add/compare plus iterative multiply and divide with HI/LO results.
// Define ALU_SEQ_DIV_EN to build the restoring divider; without it DIV/DIVU act as unsupported opcodes.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_XOR = 4'b0011;
  localparam logic [3:0] OP_ANDN = 4'b0100, OP_ORN = 4'b0101, OP_SUB = 4'b0110, OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000, OP_MULT = 4'b1001, OP_MULTU = 4'b1010;
  localparam logic [3:0] OP_DIV = 4'b1011, OP_DIVU = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE, S_MUL, S_FIX
`ifdef ALU_SEQ_DIV_EN
    , S_DIV
`endif
  } state_t;

  state_t r_state, w_next;
  logic w_accept, w_is_mul, w_is_div, w_sgn, w_c, w_v;
  logic [WIDTH-1:0] w_ma, w_mb, w_y, w_fy, w_fh;
  logic [WIDTH:0] w_add, w_sub, w_msum;
  logic [2*WIDTH-1:0] w_prod;
  logic w_fov, w_fdz;
  logic [WIDTH-1:0] r_hacc, r_lacc, r_mb, r_y, r_hi;
  logic [CW-1:0] r_cnt;
  logic r_neg_q, r_out_valid, r_zero, r_carry, r_ovfl, r_dz;

  assign in_ready = (r_state == S_IDLE);
  assign w_accept = in_valid && in_ready;
  assign w_is_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef ALU_SEQ_DIV_EN
  logic r_neg_r, r_bz, r_ovf, r_div, w_ge;
  logic [WIDTH:0] w_shift;
  assign w_is_div = (op == OP_DIV) || (op == OP_DIVU);
  assign w_shift  = {r_hacc, r_lacc[WIDTH-1]};
  assign w_ge     = w_shift >= {1'b0, r_mb};
`else
  assign w_is_div = 1'b0;
`endif
  assign w_sgn = (op == OP_MULT) || (w_is_div && op == OP_DIV);
  // Iterations run on magnitudes; signs are reapplied in FIX.
  assign w_ma  = (w_sgn && a[WIDTH-1]) ? -a : a;
  assign w_mb  = (w_sgn && b[WIDTH-1]) ? -b : b;
  assign w_add = {1'b0, a} + {1'b0, b};
  assign w_sub = {1'b0, a} - {1'b0, b};
  assign w_msum = {1'b0, r_hacc} + {1'b0, (r_lacc[0] ? r_mb : '0)};

  always_comb begin
    w_y = '0;
    w_c = 1'b0;
    w_v = 1'b0;
    case (op)
      OP_AND:  w_y = a & b;
      OP_OR:   w_y = a | b;
      OP_XOR:  w_y = a ^ b;
      OP_ANDN: w_y = a & ~b;
      OP_ORN:  w_y = a | ~b;
      OP_ADD: begin
        w_y = w_add[WIDTH-1:0];
        w_c = w_add[WIDTH];
        w_v = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_y = w_sub[WIDTH-1:0];
        w_c = w_sub[WIDTH];
        w_v = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  w_y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: w_y = {{(WIDTH-1){1'b0}}, a < b};
      default: w_y = '0;
    endcase
  end

  always_comb begin
    w_prod = r_neg_q ? -{r_hacc, r_lacc} : {r_hacc, r_lacc};
    w_fy   = w_prod[WIDTH-1:0];
    w_fh   = w_prod[2*WIDTH-1:WIDTH];
    w_fov  = 1'b0;
    w_fdz  = 1'b0;
`ifdef ALU_SEQ_DIV_EN
    if (r_div) begin
      w_fy  = r_bz ? '1 : (r_neg_q ? -r_lacc : r_lacc);
      w_fh  = r_neg_r ? -r_hacc : r_hacc;
      w_fov = r_ovf;
      w_fdz = r_bz;
    end
`endif
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mul) w_next = S_MUL;
`ifdef ALU_SEQ_DIV_EN
        else if (w_accept && w_is_div) w_next = S_DIV;
      end
      S_DIV: begin
        if (r_cnt == LAST) w_next = S_FIX;
`endif
      end
      S_MUL:   if (r_cnt == LAST) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hacc <= '0; r_lacc <= '0; r_mb <= '0; r_cnt <= '0; r_neg_q <= 1'b0;
      r_y <= '0; r_hi <= '0; r_zero <= 1'b0; r_carry <= 1'b0; r_ovfl <= 1'b0; r_dz <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      r_neg_r <= 1'b0; r_bz <= 1'b0; r_ovf <= 1'b0; r_div <= 1'b0;
`endif
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          if (w_is_mul || w_is_div) begin
            // Mul: low half holds the multiplier; div: low half shifts dividend out, quotient in.
            r_hacc  <= '0;
            r_lacc  <= w_is_mul ? w_mb : w_ma;
            r_mb    <= w_is_mul ? w_ma : w_mb;
            r_cnt   <= '0;
            r_neg_q <= w_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef ALU_SEQ_DIV_EN
            r_neg_r <= w_sgn && a[WIDTH-1];
            r_bz    <= w_is_div && (b == '0);
            r_ovf   <= w_is_div && w_sgn && (a == MIN) && (b == '1);
            r_div   <= w_is_div;
`endif
          end else begin
            r_y <= w_y; r_hi <= '0; r_zero <= (w_y == '0);
            r_carry <= w_c; r_ovfl <= w_v; r_dz <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        S_MUL: begin
          {r_hacc, r_lacc} <= {w_msum, r_lacc[WIDTH-1:1]};
          r_cnt <= r_cnt + 1'b1;
        end
`ifdef ALU_SEQ_DIV_EN
        S_DIV: begin
          r_hacc <= w_ge ? (w_shift[WIDTH-1:0] - r_mb) : w_shift[WIDTH-1:0];
          r_lacc <= {r_lacc[WIDTH-2:0], w_ge};
          r_cnt  <= r_cnt + 1'b1;
        end
`endif
        S_FIX: begin
          r_y <= w_fy; r_hi <= w_fh; r_zero <= (w_fy == '0);
          r_carry <= 1'b0; r_ovfl <= w_fov; r_dz <= w_fdz;
          r_out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign hi        = r_hi;
  assign zero      = r_zero;
  assign carry     = r_carry;
  assign overflow  = r_ovfl;
  assign div_zero  = r_dz;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corners, back-to-back streams, random ops against an arithmetic model.
module tb_alu_seq;
  localparam int W = 32;
  localparam logic [31:0] MIN = 32'h8000_0000;

  typedef struct {
    logic [31:0] y, hi;
    logic c, v, dz;
    int lat;
  } res_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic in_valid, in_ready, out_valid, zero, carry, overflow, div_zero;
  logic [3:0] op;
  logic [31:0] a, b, y, hi;
  logic iv8, rdy8, ov8, z8, c8, v8, dz8;
  logic [3:0] op8;
  logic [7:0] a8, b8, y8, hi8;

  int n_cmp = 0, n_bad = 0;

  alu_seq #(.WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .y(y), .hi(hi), .zero(zero), .carry(carry), .overflow(overflow),
    .div_zero(div_zero));

  alu_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(rdy8), .op(op8), .a(a8), .b(b8),
    .out_valid(ov8), .y(y8), .hi(hi8), .zero(z8), .carry(c8), .overflow(v8), .div_zero(dz8));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] z);
    res_t r;
    longint sx, sz, s;
    logic [63:0] p;
    logic [32:0] u;
    sx = longint'($signed(x));
    sz = longint'($signed(z));
    r = '{y: 32'h0, hi: 32'h0, c: 1'b0, v: 1'b0, dz: 1'b0, lat: 1};
    case (o)
      4'h0: r.y = x & z;
      4'h1: r.y = x | z;
      4'h3: r.y = x ^ z;
      4'h4: r.y = x & ~z;
      4'h5: r.y = x | ~z;
      4'h2: begin
        s = sx + sz; u = {1'b0, x} + {1'b0, z};
        r.y = s[31:0]; r.c = u[32];
        r.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h6: begin
        s = sx - sz;
        r.y = s[31:0]; r.c = (x < z);
        r.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h7: r.y = {31'b0, sx < sz};
      4'h8: r.y = {31'b0, x < z};
      4'h9: begin p = sx * sz; {r.hi, r.y} = p; r.lat = W + 2; end
      4'hA: begin p = {32'b0, x} * {32'b0, z}; {r.hi, r.y} = p; r.lat = W + 2; end
`ifdef ALU_SEQ_DIV_EN
      4'hB: begin
        r.lat = W + 2;
        if (z == 32'h0) begin r.y = '1; r.hi = x; r.dz = 1'b1; end
        else if (x == MIN && z == '1) begin r.y = MIN; r.hi = 32'h0; r.v = 1'b1; end
        else begin s = sx / sz; r.y = s[31:0]; s = sx % sz; r.hi = s[31:0]; end
      end
      4'hC: begin
        r.lat = W + 2;
        if (z == 32'h0) begin r.y = '1; r.hi = x; r.dz = 1'b1; end
        else begin r.y = x / z; r.hi = x % z; end
      end
`endif
      default: r.y = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return MIN;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk_res(input string tag, input res_t e);
    check({tag, "/y"}, 64'(y), 64'(e.y));
    check({tag, "/hi"}, 64'(hi), 64'(e.hi));
    check({tag, "/zero"}, 64'(zero), 64'(e.y == 32'h0));
    check({tag, "/carry"}, 64'(carry), 64'(e.c));
    check({tag, "/ovf"}, 64'(overflow), 64'(e.v));
    check({tag, "/dz"}, 64'(div_zero), 64'(e.dz));
  endtask

  task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] z, input string tag);
    res_t e;
    int n, busy;
    e = model(o, x, z);
    n = 0; busy = 0;
    @(negedge clk);
    check({tag, "/rdy"}, 64'(in_ready), 64'(1'b1));
    op = o; a = x; b = z; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
    do begin
      @(negedge clk);
      n++;
      if (!in_ready) busy++;
    end while (!out_valid && n < 100);
    check({tag, "/lat"}, 64'(n), 64'(e.lat));
    check({tag, "/busy"}, 64'(busy), 64'(e.lat - 1));
    chk_res(tag, e);
    @(negedge clk);
    check({tag, "/pulse"}, 64'(out_valid), 64'(1'b0));
    check({tag, "/hold"}, 64'(y), 64'(e.y));
  endtask

  task automatic b2b(input logic [3:0] qo[$], input logic [31:0] qa[$], input logic [31:0] qb[$]);
    res_t e;
    @(negedge clk);
    op = qo[0]; a = qa[0]; b = qb[0]; in_valid = 1'b1;
    for (int i = 0; i < qo.size(); i++) begin
      @(negedge clk);
      e = model(qo[i], qa[i], qb[i]);
      check($sformatf("b2b%0d/vld", i), 64'(out_valid), 64'(1'b1));
      chk_res($sformatf("b2b%0d_op%0h", i, qo[i]), e);
      if (i + 1 < qo.size()) begin op = qo[i+1]; a = qa[i+1]; b = qb[i+1]; end
      else in_valid = 1'b0;
    end
  endtask

  initial begin
    logic [3:0] qo[$];
    logic [31:0] qa[$], qb[$];
    logic [3:0] sops[12];
    int n, busy, pulses;
    sops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hD, 4'hE, 4'hF};
    in_valid = 1'b0; op = 4'h0; a = 32'h0; b = 32'h0;
    iv8 = 1'b0; op8 = 4'h0; a8 = 8'h0; b8 = 8'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst/y", 64'(y), 64'h0);
    check("rst/hi", 64'(hi), 64'h0);
    check("rst/flags", 64'({zero, carry, overflow, div_zero}), 64'h0);
    check("rst/vld", 64'(out_valid), 64'h0);
    check("rst/rdy", 64'(in_ready), 64'h1);

    do_op(4'h2, 32'h7FFF_FFFF, 32'h1, "add_ovf");
    do_op(4'h6, 32'h0, 32'h1, "sub_borrow");
    do_op(4'h9, 32'hFFFF_FFFD, 32'h7, "mult");
    check("mult/const", 64'({hi, y}), 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(4'hA, 32'hFFFF_FFFD, 32'h7, "multu");
    check("multu/const", 64'({hi, y}), 64'h0000_0006_FFFF_FFEB);
    do_op(4'hB, 32'hFFFF_FFF9, 32'h2, "div");
    do_op(4'hC, 32'd100, 32'd7, "divu");
    do_op(4'hB, MIN, 32'hFFFF_FFFF, "div_min");
    do_op(4'hC, 32'd5, 32'd0, "divu_z");
    do_op(4'hB, 32'hFFFF_FFF0, 32'd0, "div_z");
    do_op(4'h7, 32'hFFFF_FFFF, 32'h1, "slt");
    do_op(4'h8, 32'hFFFF_FFFF, 32'h1, "sltu");
    do_op(4'hD, 32'h1234, 32'h5678, "unsup");

    qo = '{4'h2, 4'h6}; qa = '{32'h7FFF_FFFF, 32'h0}; qb = '{32'h1, 32'h1};
    b2b(qo, qa, qb);
    qo.delete(); qa.delete(); qb.delete();
    for (int i = 0; i < 30; i++) begin
      qo.push_back(sops[$urandom_range(0, 11)]); qa.push_back(pick()); qb.push_back(pick());
    end
    b2b(qo, qa, qb);

    for (int i = 0; i < 120; i++)
      do_op(4'($urandom_range(0, 15)), pick(), pick(), $sformatf("rnd%0d", i));

    // Abort a multiply part-way through with reset.
    do_op(4'h2, 32'd5, 32'd6, "pre_rst");
    @(negedge clk);
    op = 4'h9; a = 32'd3; b = 32'd5; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort/y", 64'(y), 64'h0);
    check("abort/vld", 64'(out_valid), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort/rdy", 64'(in_ready), 64'h1);
    check("abort/outs", 64'({y, hi, zero, carry, overflow, div_zero, out_valid}), 64'h0);
    pulses = 0;
    repeat (40) begin @(negedge clk); if (out_valid) pulses++; end
    check("abort/no_vld", 64'(pulses), 64'h0);
    do_op(4'h2, 32'd1, 32'd1, "post_rst");
    check("post_rst/const", 64'(y), 64'd2);

    // 8-bit build: MULTU 0xFF x 0xFF, then a signed-overflow add.
    @(negedge clk);
    op8 = 4'hA; a8 = 8'hFF; b8 = 8'hFF; iv8 = 1'b1;
    @(posedge clk);
    #1 iv8 = 1'b0;
    n = 0; busy = 0;
    do begin @(negedge clk); n++; if (!rdy8) busy++; end while (!ov8 && n < 100);
    check("w8mul/lat", 64'(n), 64'd10);
    check("w8mul/busy", 64'(busy), 64'd9);
    check("w8mul/hi", 64'(hi8), 64'hFE);
    check("w8mul/y", 64'(y8), 64'h01);
    check("w8mul/flags", 64'({z8, c8, v8, dz8}), 64'h0);
    op8 = 4'h2; a8 = 8'h7F; b8 = 8'h01; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    check("w8add/vld", 64'(ov8), 64'h1);
    check("w8add/y", 64'(y8), 64'h80);
    check("w8add/flags", 64'({z8, c8, v8, dz8}), 64'b0010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
